execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 158 +++++++++++++++
 tb/tb_execute_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution, redirect squash, E->M register.
// Optional macro EXEC_FORWARDING_EN enables the M/W forwarding muxes.
module execute_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             JumpE,
  input  logic             BranchE,
  input  logic             ALUSrcE,
  input  logic             JALRctrlE,
  input  logic [1:0]       ResultSrcE,
  input  logic [2:0]       ALUControlE,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] ImmExtE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteW,
  input  logic [4:0]       RdW,
  input  logic [WIDTH-1:0] ResultW,
  output logic             PCSrcE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             ValidM,
  output logic [1:0]       ResultSrcM,
  output logic [4:0]       RdM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] PCPlus4M
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  logic [1:0]       squash_q, squash_d;
  logic             regwrite_m_q, memwrite_m_q, valid_m_q;
  logic [1:0]       resultsrc_m_q;
  logic [4:0]       rd_m_q;
  logic [WIDTH-1:0] aluresult_m_q, writedata_m_q, pcplus4_m_q;

  logic             v;
  logic [WIDTH-1:0] fwd_a, fwd_b, src_a, src_b, alu_res;
  alu_op_e          alu_op;

  assign v      = ValidE && (squash_q == 2'd0);
  assign alu_op = alu_op_e'(ALUControlE);

`ifdef EXEC_FORWARDING_EN
  logic             m_src_ok;
  logic [WIDTH-1:0] m_val;

  // Index 0 is never forwarded; M beats W when both match.
  assign m_src_ok = regwrite_m_q && valid_m_q && (rd_m_q != 5'd0);
  assign m_val    = (resultsrc_m_q == 2'b10) ? pcplus4_m_q : aluresult_m_q;

  always_comb begin
    fwd_a = RD1E;
    if (m_src_ok && (rd_m_q == Rs1E))
      fwd_a = m_val;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
      fwd_a = ResultW;
  end

  always_comb begin
    fwd_b = RD2E;
    if (m_src_ok && (rd_m_q == Rs2E))
      fwd_b = m_val;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
      fwd_b = ResultW;
  end
`else
  logic unused_fwd_inputs;

  assign unused_fwd_inputs = ^{RegWriteW, RdW, ResultW, Rs1E, Rs2E};
  assign fwd_a = RD1E;
  assign fwd_b = RD2E;
`endif

  assign src_a = fwd_a;
  assign src_b = ALUSrcE ? ImmExtE : fwd_b;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_XOR: alu_res = src_a ^ src_b;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLL: alu_res = src_a << src_b[4:0];
      ALU_SRL: alu_res = src_a >> src_b[4:0];
      default: alu_res = '0;
    endcase
  end

  assign PCSrcE    = v && (JumpE || (BranchE && (alu_res == '0)));
  assign PCTargetE = JALRctrlE ? {alu_res[WIDTH-1:1], 1'b0} : (PCE + ImmExtE);

  // Two wrong-path slots follow every redirect; v stays low while counting.
  always_comb begin
    squash_d = squash_q;
    if (PCSrcE)
      squash_d = 2'd2;
    else if (squash_q != 2'd0)
      squash_d = squash_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash_q      <= '0;
      regwrite_m_q  <= 1'b0;
      memwrite_m_q  <= 1'b0;
      valid_m_q     <= 1'b0;
      resultsrc_m_q <= '0;
      rd_m_q        <= '0;
      aluresult_m_q <= '0;
      writedata_m_q <= '0;
      pcplus4_m_q   <= '0;
    end else begin
      squash_q      <= squash_d;
      regwrite_m_q  <= v && RegWriteE;
      memwrite_m_q  <= v && MemWriteE;
      valid_m_q     <= v;
      resultsrc_m_q <= ResultSrcE;
      rd_m_q        <= RdE;
      aluresult_m_q <= alu_res;
      writedata_m_q <= fwd_b;
      pcplus4_m_q   <= PCPlus4E;
    end
  end

  assign RegWriteM  = regwrite_m_q;
  assign MemWriteM  = memwrite_m_q;
  assign ValidM     = valid_m_q;
  assign ResultSrcM = resultsrc_m_q;
  assign RdM        = rd_m_q;
  assign ALUResultM = aluresult_m_q;
  assign WriteDataM = writedata_m_q;
  assign PCPlus4M   = pcplus4_m_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: expected M bundles queued at issue, checked one cycle later.
module tb_execute_stage;

`ifdef EXEC_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRctrlE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ValidM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  execute_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .JALRctrlE(JALRctrlE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ValidM(ValidM),
    .ResultSrcM(ResultSrcM), .RdM(RdM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v, rw, mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic exp_t mk(input logic v, rw, mw, input logic [1:0] rs, input logic [4:0] rd,
                              input logic [31:0] alu, wd, pc4);
    mk = '{v: v, rw: rw, mw: mw, rs: rs, rd: rd, alu: alu, wd: wd, pc4: pc4};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input exp_t e);
    chk({tag, ".ValidM"},     {31'd0, ValidM},     {31'd0, e.v});
    chk({tag, ".RegWriteM"},  {31'd0, RegWriteM},  {31'd0, e.rw});
    chk({tag, ".MemWriteM"},  {31'd0, MemWriteM},  {31'd0, e.mw});
    chk({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, e.rs});
    chk({tag, ".RdM"},        {27'd0, RdM},        {27'd0, e.rd});
    chk({tag, ".ALUResultM"}, ALUResultM,          e.alu);
    chk({tag, ".WriteDataM"}, WriteDataM,          e.wd);
    chk({tag, ".PCPlus4M"},   PCPlus4M,            e.pc4);
  endtask

  task automatic idle();
    ValidE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0; JumpE = 1'b0; BranchE = 1'b0;
    ALUSrcE = 1'b0; JALRctrlE = 1'b0; ResultSrcE = 2'b00; ALUControlE = 3'b000;
    RD1E = '0; RD2E = '0; PCE = '0; ImmExtE = '0; PCPlus4E = '0;
    Rs1E = '0; Rs2E = '0; RdE = '0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
  endtask

  // Inputs are already driven; check the combinational redirect, queue the M bundle, clock once.
  task automatic issue(input string tag, input logic exp_pcsrc, input logic [31:0] exp_tgt,
                       input exp_t e);
    exp_t  got;
    string t;
    #1;
    chk({tag, ".PCSrcE"}, {31'd0, PCSrcE}, {31'd0, exp_pcsrc});
    if (exp_pcsrc) chk({tag, ".PCTargetE"}, PCTargetE, exp_tgt);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      got = sb_q.pop_front();
      t   = tag_q.pop_front();
      chk_m(t, got);
    end
  endtask

  task automatic alu_vec(input string tag, input logic [2:0] op, input logic [31:0] a, b, exp);
    idle();
    ValidE = 1'b1; ALUControlE = op; RD1E = a; RD2E = b;
    issue(tag, 1'b0, '0, mk(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, exp, b, 32'd0));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12;
    chk_m("reset", mk(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0));
    chk("reset.PCSrcE", {31'd0, PCSrcE}, 32'd0);
    rst = 1'b0;

    idle(); ValidE = 1; RegWriteE = 1; RdE = 1; RD1E = 5; RD2E = 7; PCPlus4E = 32'h4;
    issue("add", 1'b0, '0, mk(1, 1, 0, 2'b00, 5'd1, 32'd12, 32'd7, 32'h4));

    idle(); ValidE = 1; RegWriteE = 1; RdE = 3; RD1E = 32'h10; ALUSrcE = 1;
    issue("raw1", 1'b0, '0, mk(1, 1, 0, 2'b00, 5'd3, 32'h10, 32'd0, 32'd0));

    idle(); ValidE = 1; RegWriteE = 1; RdE = 4; Rs1E = 3; RD1E = 0; ImmExtE = 4; ALUSrcE = 1;
    RegWriteW = 1; RdW = 3; ResultW = 32'h99;
    issue("raw2_m_over_w", 1'b0, '0, mk(1, 1, 0, 2'b00, 5'd4, FWD ? 32'h14 : 32'h4, 32'd0, 32'd0));

    idle(); ValidE = 1; ALUControlE = 3'b011; RD1E = 32'h0A; Rs2E = 7;
    RegWriteW = 1; RdW = 7; ResultW = 32'h55;
    issue("w_fwd_b", 1'b0, '0,
          mk(1, 0, 0, 2'b00, 5'd0, FWD ? 32'h5F : 32'h0A, FWD ? 32'h55 : 32'h0, 32'd0));

    idle(); ValidE = 1; RegWriteE = 1; RdE = 0; RD1E = 32'h77; ALUSrcE = 1;
    issue("write_x0", 1'b0, '0, mk(1, 1, 0, 2'b00, 5'd0, 32'h77, 32'd0, 32'd0));

    idle(); ValidE = 1; MemWriteE = 1; RD1E = 1; ImmExtE = 1; ALUSrcE = 1; RD2E = 32'h33;
    RegWriteW = 1; RdW = 0; ResultW = 32'hFF;
    issue("no_fwd_x0", 1'b0, '0, mk(1, 0, 1, 2'b00, 5'd0, 32'd2, 32'h33, 32'd0));

    alu_vec("sub",   3'b001, 32'd5,        32'd7,        32'hFFFF_FFFE);
    alu_vec("and",   3'b010, 32'hF0F0,     32'hFF00,     32'hF000);
    alu_vec("xor",   3'b100, 32'hFF,       32'h0F,       32'hF0);
    alu_vec("slt_t", 3'b101, 32'hFFFF_FFFF, 32'd1,       32'd1);
    alu_vec("slt_f", 3'b101, 32'd1,        32'hFFFF_FFFF, 32'd0);
    alu_vec("sll",   3'b110, 32'd1,        32'h21,       32'd2);
    alu_vec("srl",   3'b111, 32'h8000_0000, 32'd4,       32'h0800_0000);

    idle(); ValidE = 1; BranchE = 1; ALUControlE = 3'b001; RD1E = 9; RD2E = 9;
    PCE = 32'h100; ImmExtE = 32'h20;
    issue("beq", 1'b1, 32'h120, mk(1, 0, 0, 2'b00, 5'd0, 32'd0, 32'd9, 32'd0));
    for (int unsigned i = 0; i < 2; i++) begin
      idle(); ValidE = 1; RegWriteE = 1; MemWriteE = 1; JumpE = 1; RD1E = 1; RD2E = 1; RdE = 2;
      issue($sformatf("beq_sq%0d", i), 1'b0, '0, mk(0, 0, 0, 2'b00, 5'd2, 32'd2, 32'd1, 32'd0));
    end
    idle(); ValidE = 1; BranchE = 1; ALUControlE = 3'b001; RD1E = 3; RD2E = 4;
    issue("beq_live", 1'b0, '0, mk(1, 0, 0, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'd4, 32'd0));

    idle(); ValidE = 1; JumpE = 1; JALRctrlE = 1; ResultSrcE = 2'b10; RegWriteE = 1; RdE = 5;
    RD1E = 32'h203; ALUSrcE = 1; PCE = 32'h300; PCPlus4E = 32'h304;
    issue("jalr", 1'b1, 32'h202, mk(1, 1, 0, 2'b10, 5'd5, 32'h203, 32'd0, 32'h304));
    idle(); ValidE = 1; RegWriteE = 1; RdE = 6; Rs1E = 5; ImmExtE = 32'h10; ALUSrcE = 1;
    issue("jalr_sq0_pc4", 1'b0, '0, mk(0, 0, 0, 2'b00, 5'd6, FWD ? 32'h314 : 32'h10, 32'd0, 32'd0));
    idle(); ValidE = 1; JumpE = 1; Rs1E = 5; RD1E = 1; ALUSrcE = 1;
    issue("jalr_sq1", 1'b0, '0, mk(0, 0, 0, 2'b00, 5'd0, 32'd1, 32'd0, 32'd0));

    idle(); ValidE = 1; ResultSrcE = 2'b10; RegWriteE = 1; RdE = 6; RD1E = 1; ALUSrcE = 1;
    PCPlus4E = 32'h404;
    issue("pc4_src", 1'b0, '0, mk(1, 1, 0, 2'b10, 5'd6, 32'd1, 32'd0, 32'h404));
    idle(); ValidE = 1; RegWriteE = 1; RdE = 7; Rs1E = 6; ImmExtE = 8; ALUSrcE = 1;
    issue("pc4_fwd", 1'b0, '0, mk(1, 1, 0, 2'b00, 5'd7, FWD ? 32'h40C : 32'h8, 32'd0, 32'd0));

    idle(); ValidE = 1; JumpE = 1; RegWriteE = 1; RdE = 1; ResultSrcE = 2'b10;
    RD1E = 32'h11; RD2E = 32'h22; PCE = 32'h40; ImmExtE = 32'h10; PCPlus4E = 32'h44;
    issue("jal", 1'b1, 32'h50, mk(1, 1, 0, 2'b10, 5'd1, 32'h33, 32'h22, 32'h44));
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk_m("async_rst", mk(0, 0, 0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0));
    chk("async_rst.PCSrcE", {31'd0, PCSrcE}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(); ValidE = 1; RegWriteE = 1; RdE = 9; RD1E = 2; RD2E = 3;
    issue("post_rst", 1'b0, '0, mk(1, 1, 0, 2'b00, 5'd9, 32'd5, 32'd3, 32'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
